adder16_arbiter: RTL and testbench

Shares one combinational Adder16 between two requesters: round-robin arbitration, operand capture, registered result, per-requester ack/done handshake. Sits between two independent operand sources (e.g. PC-increment and ALU-offset paths) and the single adder instance. One operation is in flight at a time; result is registered and broadcast on a shared bus with a per-requester done strobe.

---
 rtl/adder16_arbiter_pkg.sv | 30 +++
 rtl/adder16.sv | 10 +
 rtl/adder16_arbiter.sv | 100 ++++++++++
 tb/tb_adder16_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder16_arbiter_pkg.sv
// Shared definitions for the two-requester Adder16 arbiter: FSM state
// encoding, requester indices and the grant-selection helper.
package adder16_arbiter_pkg;

    localparam int WIDTH = 16;

    // Requester indices; the grant and last-served registers hold one of these.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pick the requester to serve. A lone request always wins. On a tie,
    // round-robin serves whoever was not served last; fixed priority
    // always serves requester 0.
    function automatic logic pick(input logic rr_en,
                                  input logic req0,
                                  input logic req1,
                                  input logic last);
        if (req0 && req1) begin
            return rr_en ? ~last : REQ0;
        end
        return req1 ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/adder16.sv
// Adder16: plain combinational 16-bit adder, carry discarded.
module adder16 (
    input  logic [15:0] op1,
    input  logic [15:0] op2,
    output logic [15:0] sum
);

    assign sum = op1 + op2;

endmodule

// File: rtl/adder16_arbiter.sv
// Shares one Adder16 between two requesters. A request is sampled in IDLE,
// operands are captured with an ack pulse, the sum is registered in EXEC,
// and DONE pulses the done strobe of the granted requester. One operation
// is in flight at a time.
module adder16_arbiter
    import adder16_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             gnt;
    logic             last;
    logic             sel;
    logic [WIDTH-1:0] sum;

    // Grant candidate for the current IDLE cycle.
    always_comb begin
        // NOTE: give every always_comb output a value on every path, or synthesis infers a latch.
        sel = REQ0;
        sel = pick(RR_EN, req0, req1, last);
    end

    // The single shared adder works on the captured operands only.
    adder16 u_adder (
        .op1 (op_a),
        .op2 (op_b),
        .sum (sum)
    );

    // Arbitration FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            gnt   <= REQ0;
            last  <= REQ1;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            res   <= '0;
            busy  <= 1'b0;
        end else begin
            // Handshake strobes are single-cycle pulses unless set below.
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt   <= sel;
                        last  <= sel;
                        op_a  <= (sel == REQ1) ? a1 : a0;
                        op_b  <= (sel == REQ1) ? b1 : b0;
                        ack0  <= (sel == REQ0);
                        ack1  <= (sel == REQ1);
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res   <= sum;
                    done0 <= (gnt == REQ0);
                    done1 <= (gnt == REQ1);
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder16_arbiter.sv
// Directed bench for adder16_arbiter. Two instances run in lockstep on the
// same stimulus: one round-robin, one fixed priority. Expected results are
// queued when a request is driven and popped when a done strobe appears.
module tb_adder16_arbiter;

    typedef struct packed {
        logic        who;
        logic [15:0] sum;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;

    logic        r_ack0, r_ack1, r_done0, r_done1, r_busy;
    logic [15:0] r_res;
    logic        f_ack0, f_ack1, f_done0, f_done1, f_busy;
    logic [15:0] f_res;

    exp_t q_rr[$];
    exp_t q_fx[$];

    int checks = 0;
    int errors = 0;

    adder16_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk (clk), .rst (rst),
        .req0 (req0), .a0 (a0), .b0 (b0),
        .req1 (req1), .a1 (a1), .b1 (b1),
        .ack0 (r_ack0), .ack1 (r_ack1),
        .done0 (r_done0), .done1 (r_done1),
        .res (r_res), .busy (r_busy)
    );

    adder16_arbiter #(.RR_EN(1'b0)) u_fx (
        .clk (clk), .rst (rst),
        .req0 (req0), .a0 (a0), .b0 (b0),
        .req1 (req1), .a1 (a1), .b1 (b1),
        .ack0 (f_ack0), .ack1 (f_ack1),
        .done0 (f_done0), .done1 (f_done1),
        .res (f_res), .busy (f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_both(input logic who, input logic [15:0] sum);
        exp_t e;
        e.who = who;
        e.sum = sum;
        q_rr.push_back(e);
        q_fx.push_back(e);
    endtask

    // Scoreboard and one-hot handshake monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        check("rr_onehot", 32'($countones({r_ack0, r_ack1, r_done0, r_done1}) <= 1), 1);
        check("fx_onehot", 32'($countones({f_ack0, f_ack1, f_done0, f_done1}) <= 1), 1);
        if (r_done0 || r_done1) begin
            if (q_rr.size() == 0) begin
                check("rr_done_unexpected", {r_done1, r_done0}, 0);
            end else begin
                e = q_rr.pop_front();
                check("rr_done_who", r_done1, e.who);
                check("rr_res", r_res, e.sum);
            end
        end
        if (f_done0 || f_done1) begin
            if (q_fx.size() == 0) begin
                check("fx_done_unexpected", {f_done1, f_done0}, 0);
            end else begin
                e = q_fx.pop_front();
                check("fx_done_who", f_done1, e.who);
                check("fx_res", f_res, e.sum);
            end
        end
    end

    // Single operation from one requester, started and finished on a falling edge.
    task automatic run_single(input logic who, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] sum;
        sum = a + b;
        push_both(who, sum);
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        check("single_ack", {r_ack1, r_ack0}, who ? 2'b10 : 2'b01);
        check("single_busy_exec", r_busy, 1);
        @(negedge clk);
        check("single_ack_clear", {r_ack1, r_ack0}, 0);
        check("single_done", {r_done1, r_done0}, who ? 2'b10 : 2'b01);
        check("single_busy_done", r_busy, 1);
        @(negedge clk);
        check("single_busy_idle", r_busy, 0);
        check("single_done_clear", {r_done1, r_done0}, 0);
    endtask

    // Wait (bounded) for the next ack from the round-robin instance.
    task automatic wait_rr_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(r_ack0 || r_ack1) && n < 12);
        check("ack_timeout", r_ack0 | r_ack1, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        check("rst_rr_strobes", {r_ack0, r_ack1, r_done0, r_done1, r_busy}, 0);
        check("rst_rr_res", r_res, 16'h0000);
        check("rst_fx_strobes", {f_ack0, f_ack1, f_done0, f_done1, f_busy}, 0);
        check("rst_fx_res", f_res, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // First operation: 0 + 4.
        run_single(1'b0, 16'h0000, 16'h0004);

        // Back-to-back req0 held high: 4+4 then 4+8, acks three cycles apart.
        a0 = 16'h0004; b0 = 16'h0004; req0 = 1'b1;
        push_both(1'b0, 16'h0008);
        wait_rr_ack(n);
        check("b2b_first_ack0", r_ack0, 1);
        b0 = 16'h0008;
        push_both(1'b0, 16'h000C);
        wait_rr_ack(n);
        check("b2b_ack_spacing", n, 3);
        check("b2b_second_ack0", r_ack0, 1);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Wraparound on requester 1.
        run_single(1'b1, 16'hFFFF, 16'h0001);
        run_single(1'b1, 16'h8000, 16'h8000);

        // Both requests held: round-robin alternates, fixed priority stays on 0
        // until req0 drops.
        a0 = 16'h0001; b0 = 16'h0001; a1 = 16'h0002; b1 = 16'h0002;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.who = (i == 4) ? 1'b1 : 1'(i % 2);
            e.sum = e.who ? 16'h0004 : 16'h0002;
            q_rr.push_back(e);
            e.who = (i == 4);
            e.sum = e.who ? 16'h0004 : 16'h0002;
            q_fx.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            logic rr_who;
            rr_who = (i == 4) ? 1'b1 : 1'(i % 2);
            wait_rr_ack(n);
            check("both_rr_grant", {r_ack1, r_ack0}, rr_who ? 2'b10 : 2'b01);
            check("both_fx_grant", {f_ack1, f_ack0}, (i == 4) ? 2'b10 : 2'b01);
            if (i == 3) req0 = 1'b0;
            if (i == 4) req1 = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset during EXEC drops the op and restores the last pointer.
        a0 = 16'h0009; b0 = 16'h0009; req0 = 1'b1;
        @(negedge clk);
        check("rst_exec_ack0", r_ack0, 1);
        req0 = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check("rst_exec_strobes", {r_ack0, r_ack1, r_done0, r_done1}, 0);
        check("rst_exec_res", r_res, 16'h0000);
        check("rst_exec_busy", r_busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_exec_no_done", {r_done1, r_done0, f_done1, f_done0}, 0);

        // After reset a tie goes to requester 0 again.
        a0 = 16'h0001; b0 = 16'h0001; a1 = 16'h0002; b1 = 16'h0002;
        req0 = 1'b1; req1 = 1'b1;
        push_both(1'b0, 16'h0002);
        wait_rr_ack(n);
        check("rst_ptr_rr_grant", {r_ack1, r_ack0}, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset and request in the same cycle: reset wins.
        rst = 1'b1; req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0005;
        @(negedge clk);
        check("rst_req_no_ack", {r_ack1, r_ack0}, 0);
        check("rst_req_no_busy", r_busy, 0);
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);
        check("rst_req_idle", r_busy, 0);

        // Normal operation after reset.
        run_single(1'b1, 16'h0003, 16'h0005);

        repeat (4) @(negedge clk);
        check("rr_queue_empty", q_rr.size(), 0);
        check("fx_queue_empty", q_fx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
